hours: RTL
==========

# hours

Hour-of-day counter that consumes the `changeHour` roll-over pulse from the minutes counter and produces the hour value for the clock display. Supports manual adjust (step up/down and direct load) with roll-overs that arrive during adjust held pending and applied on exit. Emits a single-cycle `changeDay` pulse on the natural 23→0 wrap for a downstream day/date stage.

## Interface
Parameters:
- `MAX_HOUR`, 23: last hour value before wrap to 0.

Ports:
- `clkMSec`  input  1  system clock (millisecond tick clock used by the clock chain)
- `resetN`  input  1  reset; synchronous, active-high
- `changeHour`  input  1  single-cycle pulse from minutes counter on 59→0 wrap
- `setEn`  input  1  level; high = adjust mode
- `setUp`  input  1  single-cycle pulse; increment hour (adjust mode only)
- `setDown`  input  1  single-cycle pulse; decrement hour (adjust mode only)
- `loadEn`  input  1  single-cycle pulse; load `loadHour` (any mode)
- `loadHour`  input  5  value to load
- `loadErr`  output  1  single-cycle pulse; load rejected (value > MAX_HOUR)
- `changeDay`  output  1  single-cycle pulse on natural wrap MAX_HOUR→0
- `hour`  output  5  current hour, 0..MAX_HOUR
- `pending`  output  1  roll-over held during adjust
- `hour12`  output  4  1..12 display hour (only with HOURS_12H_EN)
- `pm`  output  1  high for hours 12..23 (only with HOURS_12H_EN)

## Operation
- Two states, register `mode`: RUN (setEn=0) and SET (setEn=1). `mode` follows `setEn` with one cycle of latency; all decisions use registered `mode`.
- Priority per cycle: reset > loadEn > setUp/setDown (SET only) > changeHour.
- RUN: `changeHour` → hour+1; at MAX_HOUR → 0 and `changeDay`=1 next cycle. setUp/setDown ignored.
- SET: `changeHour` sets `pending`=1 (saturates; multiple roll-overs in one adjust session count once). No `changeDay` in SET.
- SET: `setUp` → hour+1 mod (MAX_HOUR+1); `setDown` → hour−1, 0→MAX_HOUR. Both in same cycle → no change. Adjust wraps never pulse `changeDay`.
- SET→RUN transition cycle: if `pending`, apply one increment (normal RUN rules, including `changeDay` on wrap); clear `pending`. A `changeHour` arriving in that same cycle is also counted: net +2, at most one `changeDay` per wrap crossed (two wraps impossible with MAX_HOUR≥1).
- `loadEn`: `loadHour` ≤ MAX_HOUR → hour := loadHour, `pending` cleared; else hour unchanged, `loadErr`=1 one cycle. A `changeHour` in the load cycle is dropped (load wins).
- Arithmetic in 5-bit unsigned; no intermediate value > MAX_HOUR+1.

## Timing
- Reset values: hour=0, mode=RUN, pending=0, changeDay=0, loadErr=0, hour12=12, pm=0.
- All outputs registered; every input event visible on outputs one clock after sampling.
- `changeDay` and `loadErr` high exactly one cycle.
- `changeDay` asserts in the same cycle `hour` first shows 0.
- Reset asserted mid-adjust or with pending set: all state to reset values next edge; pending roll-over discarded.
- `changeHour` assumed ≥2 cycles apart; back-to-back pulses each counted.

## Configuration
- `HOURS_12H_EN`: when defined, `hour12` and `pm` ports exist; hour12 = hour mod 12, 0 mapped to 12; pm = (hour ≥ 12); both registered, updated with `hour`. When undefined, the ports and logic are absent; 24-hour `hour` behaviour unchanged.

## Test plan
- Reset, then 24 `changeHour` pulses in RUN → hour 1..23 then 0; `changeDay` one cycle exactly with hour=0; no other `changeDay`.
- hour=5, setEn=1, 3 changeHour pulses, setUp ×2 → hour=7, pending=1; setEn=0 → hour=8, pending=0, no changeDay.
- hour=23 in SET with pending=1, exit SET → hour=0, `changeDay` one cycle; setDown at hour=0 in SET → 23, no changeDay.
- loadEn with loadHour=24 → loadErr one cycle, hour unchanged; loadHour=17 with simultaneous changeHour → hour=17 (not 18).
- setUp and setDown same cycle in SET at hour=9 → hour stays 9; resetN during SET with pending → hour=0, pending=0, mode RUN.
- With HOURS_12H_EN: hour 0→12/pm=0, 12→12/pm=1, 13→1/pm=1, 23→11/pm=1.

Source files
------------

// File: rtl/hours.sv
// Hour-of-day counter driven by the minutes roll-over, with manual adjust and load.
// Optional 12-hour display outputs (hour12, pm) are built when HOURS_12H_EN is defined.
module hours #(
    parameter int unsigned MAX_HOUR = 23
) (
    input  logic       clkMSec,
    input  logic       resetN,
    input  logic       changeHour,
    input  logic       setEn,
    input  logic       setUp,
    input  logic       setDown,
    input  logic       loadEn,
    input  logic [4:0] loadHour,
    output logic       loadErr,
    output logic       changeDay,
    output logic [4:0] hour,
    output logic       pending
`ifdef HOURS_12H_EN
    ,
    output logic [3:0] hour12,
    output logic       pm
`endif
);

    localparam int unsigned HW = 5;
    localparam logic [HW-1:0] MAX = HW'(MAX_HOUR);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } mode_t;

    mode_t         mode;
    logic [HW-1:0] hour_n;
    logic          pending_n;
    logic          day_n;
    logic          err_n;
    logic          inc_a;
    logic          inc_b;
    logic          exiting;

    // Next-state: load, then adjust, then roll-over increments (up to two on adjust exit).
    always_comb begin
        hour_n    = hour;
        pending_n = pending;
        day_n     = 1'b0;
        err_n     = 1'b0;
        inc_a     = 1'b0;
        inc_b     = 1'b0;
        exiting   = (mode == SET) && !setEn;

        if (loadEn) begin
            if (loadHour <= MAX) begin
                hour_n    = loadHour;
                pending_n = 1'b0;
            end else begin
                err_n = 1'b1;
                if (exiting) begin
                    pending_n = 1'b0;
                end
            end
        end else if (mode == RUN) begin
            inc_a = changeHour;
        end else if (exiting) begin
            inc_a     = pending;
            inc_b     = changeHour;
            pending_n = 1'b0;
        end else begin
            pending_n = pending | changeHour;
            if (setUp && !setDown) begin
                hour_n = (hour == MAX) ? '0 : hour + HW'(1);
            end else if (setDown && !setUp) begin
                hour_n = (hour == '0) ? MAX : hour - HW'(1);
            end
        end

        // Stepwise increments keep every intermediate value within 0..MAX_HOUR.
        if (inc_a) begin
            if (hour_n == MAX) begin
                hour_n = '0;
                day_n  = 1'b1;
            end else begin
                hour_n = hour_n + HW'(1);
            end
        end
        if (inc_b) begin
            if (hour_n == MAX) begin
                hour_n = '0;
                day_n  = 1'b1;
            end else begin
                hour_n = hour_n + HW'(1);
            end
        end
    end

`ifdef HOURS_12H_EN
    function automatic logic [3:0] to_12h(input logic [HW-1:0] h);
        if (h == '0) begin
            return 4'd12;
        end else if (h > HW'(12)) begin
            return 4'(h - HW'(12));
        end else begin
            return 4'(h);
        end
    endfunction
`endif

    always_ff @(posedge clkMSec) begin
        if (resetN) begin
            mode      <= RUN;
            hour      <= '0;
            pending   <= 1'b0;
            changeDay <= 1'b0;
            loadErr   <= 1'b0;
`ifdef HOURS_12H_EN
            hour12    <= 4'd12;
            pm        <= 1'b0;
`endif
        end else begin
            mode      <= setEn ? SET : RUN;
            hour      <= hour_n;
            pending   <= pending_n;
            changeDay <= day_n;
            loadErr   <= err_n;
`ifdef HOURS_12H_EN
            hour12    <= to_12h(hour_n);
            pm        <= (hour_n >= HW'(12));
`endif
        end
    end

endmodule
